// File: rtl/fifo_rd_stream.sv
// Async FIFO read-side drainer: 2-entry skid buffer, valid/ready out.
// Define FIFO_RD_LEVEL_EN to build the read-domain fill-level output.
module fifo_rd_stream #(
    parameter int DATASIZE = 8,
    parameter int ADDRSIZE = 4
) (
    input  logic                i_rd_clk,
    input  logic                i_rd_rst_n,
    input  logic                i_empty,
    output logic                o_rd_en,
    input  logic [DATASIZE-1:0] i_rd_data,
    input  logic [ADDRSIZE:0]   i_rd_ptr,
    input  logic [ADDRSIZE:0]   i_wr_ptr_clx,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [DATASIZE-1:0] o_data,
    output logic [ADDRSIZE:0]   o_rd_level
);

    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic                inflight;
    logic                pop;
    logic                push;
    logic [2:0]          fill;
    logic [DATASIZE-1:0] buf0;
    logic [DATASIZE-1:0] buf1;

    assign o_valid = (state != S0);
    assign o_data  = buf0;
    assign pop     = o_valid & i_ready;
    assign push    = inflight;

    // Words held or arriving after this cycle's pop; keep it below two.
    assign fill    = {1'b0, state} + {2'b0, inflight} - {2'b0, pop};
    assign o_rd_en = i_rd_rst_n & ~i_empty & (fill < 3'd2);

    always_ff @(posedge i_rd_clk or negedge i_rd_rst_n) begin
        if (!i_rd_rst_n) begin
            state    <= S0;
            inflight <= 1'b0;
        end else begin
            state    <= state_nxt;
            inflight <= o_rd_en;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S0: if (push) state_nxt = S1;
            S1: begin
                if (push && !pop)      state_nxt = S2;
                else if (pop && !push) state_nxt = S0;
            end
            S2: if (pop && !push) state_nxt = S1;
            default: state_nxt = S0;
        endcase
    end

    always_ff @(posedge i_rd_clk or negedge i_rd_rst_n) begin
        if (!i_rd_rst_n) begin
            buf0 <= '0;
            buf1 <= '0;
        end else if (pop) begin
            if (push) begin
                if (state == S2) begin
                    buf0 <= buf1;
                    buf1 <= i_rd_data;
                end else begin
                    buf0 <= i_rd_data;
                end
            end else begin
                buf0 <= buf1;
            end
        end else if (push) begin
            if (state == S0) buf0 <= i_rd_data;
            else             buf1 <= i_rd_data;
        end
    end

    overflow_a : assert property (
        @(posedge i_rd_clk) disable iff (!i_rd_rst_n)
        !(state == S2 && push && !pop)
    );

`ifdef FIFO_RD_LEVEL_EN
    function automatic logic [ADDRSIZE:0] gray2bin(
        input logic [ADDRSIZE:0] g
    );
        logic [ADDRSIZE:0] b;
        b[ADDRSIZE] = g[ADDRSIZE];
        for (int i = ADDRSIZE - 1; i >= 0; i--)
            b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    logic [ADDRSIZE:0] wbin;
    logic [ADDRSIZE:0] rbin;

    assign wbin = gray2bin(i_wr_ptr_clx);
    assign rbin = gray2bin(i_rd_ptr);

    // Modular subtraction absorbs pointer wrap.
    always_ff @(posedge i_rd_clk or negedge i_rd_rst_n) begin
        if (!i_rd_rst_n) o_rd_level <= '0;
        else             o_rd_level <= wbin - rbin;
    end
`else
    logic unused_ptrs;
    assign unused_ptrs = ^{i_rd_ptr, i_wr_ptr_clx};
    assign o_rd_level  = '0;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: FIFO memory model plus scoreboard queue.
// Level expectations follow whether FIFO_RD_LEVEL_EN is defined.
module tb_fifo_rd_stream;

`ifdef FIFO_RD_LEVEL_EN
    localparam bit LVL_EN = 1'b1;
`else
    localparam bit LVL_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       empty;
    logic       rd_en;
    logic [7:0] rd_data;
    logic [4:0] rd_ptr = '0;
    logic [4:0] wr_ptr = '0;
    logic       valid;
    logic       ready = 1'b0;
    logic [7:0] data;
    logic [4:0] level;

    logic [7:0] mem [16];
    logic [4:0] wcnt = '0;
    logic [4:0] rcnt;
    logic [7:0] q [$];
    logic       prev_hold = 1'b0;
    logic [7:0] held_d = '0;
    int         checks = 0;
    int         errors = 0;
    int         pops = 0;

    always #5 clk = ~clk;

    fifo_rd_stream dut (
        .i_rd_clk    (clk),
        .i_rd_rst_n  (rst_n),
        .i_empty     (empty),
        .o_rd_en     (rd_en),
        .i_rd_data   (rd_data),
        .i_rd_ptr    (rd_ptr),
        .i_wr_ptr_clx(wr_ptr),
        .o_valid     (valid),
        .i_ready     (ready),
        .o_data      (data),
        .o_rd_level  (level)
    );

    assign empty = (wcnt == rcnt);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rcnt    <= '0;
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rcnt[3:0]];
            rcnt    <= rcnt + 5'd1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] gray(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    always @(negedge clk) begin
        if (rst_n && prev_hold)
            check("hold", {24'd0, data}, {24'd0, held_d});
        if (rst_n && valid && ready) begin
            pops++;
            if (q.size() == 0) check("underrun", 32'd1, 32'd0);
            else check("data", {24'd0, data}, {24'd0, q.pop_front()});
        end
        prev_hold = rst_n && valid && !ready;
        held_d    = data;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            mem[wcnt[3:0]] = base + 8'(i);
            q.push_back(base + 8'(i));
            wcnt = wcnt + 5'd1;
        end
    endtask

    task automatic drain(input string tag);
        int c;
        c = 0;
        while ((q.size() != 0 || valid) && c < 40) begin
            @(negedge clk);
            c++;
        end
        check(tag, q.size(), 0);
    endtask

    task automatic set_ptrs(input logic [4:0] wb, input logic [4:0] rb);
        wr_ptr = gray(wb);
        rd_ptr = gray(rb);
    endtask

    initial begin
        int fe, fv, lv, le, ne, nv, p0;
        logic [4:0] rb, oc;

        #12;
        check("rst_valid", valid, 0);
        check("rst_rden", rd_en, 0);
        check("rst_data", data, 0);
        check("rst_level", level, 0);
        step();
        rst_n = 1'b1;
        step();
        step();
        check("idle_valid", valid, 0);
        check("idle_rden", rd_en, 0);

        ready = 1'b1;
        load(5, 8'h11);
        fe = -1; fv = -1; lv = -1; le = -1; ne = 0; nv = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (rd_en) begin
                if (fe < 0) fe = c;
                le = c;
                ne++;
            end
            if (valid) begin
                if (fv < 0) fv = c;
                lv = c;
                nv++;
            end
        end
        check("t1_en_cnt", ne, 5);
        check("t1_en_span", le - fe, 4);
        check("t1_latency", fv - fe, 2);
        check("t1_v_cnt", nv, 5);
        check("t1_v_span", lv - fv, 4);

        step();
        ready = 1'b0;
        load(8, 8'h11);
        ne = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (rd_en) ne++;
        end
        check("t2_en_cnt", ne, 2);
        check("t2_valid", valid, 1);
        check("t2_head", data, 8'h11);
        step();
        ready = 1'b1;
        fv = -1; lv = -1; nv = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (c == 0) check("t2_reassert", rd_en, 1);
            if (valid) begin
                if (fv < 0) fv = c;
                lv = c;
                nv++;
            end
        end
        check("t2_v_cnt", nv, 8);
        check("t2_v_span", lv - fv, 7);

        p0 = pops;
        load(10, 8'h40);
        for (int c = 0; c < 40; c++) begin
            step();
            if (c < 16) ready = (c % 2 == 0);
            else        ready = 1'($urandom_range(0, 1));
        end
        step();
        ready = 1'b1;
        drain("t3_drain");
        check("t3_pops", pops - p0, 10);

        step();
        set_ptrs(5'd3, 5'd30);
        @(negedge clk);
        check("lvl_lag", level, 0);
        @(negedge clk);
        check("lvl_wrap", level, LVL_EN ? 5 : 0);
        step();
        set_ptrs(5'd7, 5'd7);
        @(negedge clk);
        @(negedge clk);
        check("lvl_equal", level, 0);
        step();
        set_ptrs(5'd21, 5'd5);
        @(negedge clk);
        @(negedge clk);
        check("lvl_msb", level, LVL_EN ? 16 : 0);
        for (int i = 0; i < 4; i++) begin
            step();
            rb = 5'($urandom_range(0, 31));
            oc = 5'($urandom_range(0, 16));
            set_ptrs(rb + oc, rb);
            @(negedge clk);
            @(negedge clk);
            check("lvl_rand", level, LVL_EN ? {27'd0, oc} : 0);
        end
        step();
        set_ptrs(5'd21, 5'd5);

        ready = 1'b0;
        load(6, 8'h60);
        for (int c = 0; c < 4; c++) step();
        check("pre_rst_valid", valid, 1);
        check("pre_rst_data", data, 8'h60);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", valid, 0);
        check("mid_rst_rden", rd_en, 0);
        check("mid_rst_data", data, 0);
        check("mid_rst_level", level, 0);
        wcnt = '0;
        q.delete();
        set_ptrs(5'd0, 5'd0);
        step();
        rst_n = 1'b1;
        step();
        ready = 1'b1;
        p0 = pops;
        load(3, 8'h70);
        drain("t5_drain");
        check("t5_pops", pops - p0, 3);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
